// File: rtl/nibble_serial_addsub.sv
// ============================================================================
// nibble_serial_addsub : 16-bit signed add/sub through one 4-bit ripple slice,
//                        one nibble per cycle, saturating on signed overflow.
// Revision 1.0
// ============================================================================
`default_nettype none

module nibble_serial_addsub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [1:0]  cnt;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        c;
  logic [11:0] raw;

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [3:0]  slice_sum;
  logic [4:0]  carry;
  logic        accept;
  logic        final_edge;
  logic        ovf;
  logic [15:0] full_raw;
  logic [15:0] result;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == 2'd3) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  assign accept     = (state == S_IDLE) && start;
  assign final_edge = (state == S_RUN) && (cnt == 2'd3);

  // ---------------------------------------------------------------- slice
  assign nib_a    = op_a[{cnt, 2'b00} +: 4];
  assign nib_b    = op_b[{cnt, 2'b00} +: 4];
  assign carry[0] = c;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign slice_sum[i] = nib_a[i] ^ nib_b[i] ^ carry[i];
    assign carry[i+1]   = (nib_a[i] & nib_b[i]) | (carry[i] & (nib_a[i] ^ nib_b[i]));
  end

  // At the final nibble carry[3] is the carry into bit 15, carry[4] the carry out.
  assign full_raw = {slice_sum, raw};
  assign ovf      = carry[3] ^ carry[4];

  always_comb begin
    result = full_raw;
    if (ovf) begin
      result = op_a[15] ? 16'h8000 : 16'h7FFF;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      op_a <= 16'h0000;
      op_b <= 16'h0000;
      c    <= 1'b0;
      raw  <= 12'h000;
    end else if (accept) begin
      cnt  <= 2'd0;
      op_a <= a;
      op_b <= sub ? ~b : b;
      c    <= sub;
      raw  <= 12'h000;
    end else if (state == S_RUN) begin
      cnt <= cnt + 2'd1;
      c   <= carry[4];
      case (cnt)
        2'd0:    raw[3:0]  <= slice_sum;
        2'd1:    raw[7:4]  <= slice_sum;
        2'd2:    raw[11:8] <= slice_sum;
        default: raw       <= raw;
      endcase
    end
  end

  // ---------------------------------------------------------------- results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      sum    <= 16'h0000;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      done <= final_edge;
      if (final_edge) begin
        sum    <= result;
        flag_z <= (result == 16'h0000);
        flag_v <= ovf;
        flag_n <= result[15];
      end
    end
  end

endmodule

`default_nettype wire
